// File: rtl/burst_master.sv
// burst_master: turns single line read/write requests into memory bursts.
// Reads issue one burst command of LINE_WORDS beats and collect the returned
// words. Writes issue LINE_WORDS single-beat commands at consecutive word
// addresses. Every completed line produces a one-cycle rsp_valid pulse.
module burst_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BURSTLEN_WIDTH = 2,
   parameter int LINE_WORDS     = 4
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_wr,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
   output logic                             rsp_valid,
   output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [BURSTLEN_WIDTH-1:0]        mem_burst_len,
   output logic [DATA_WIDTH-1:0]            mem_wdata,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   output logic                             mem_wr,
   output logic                             mem_rd,
   input  logic                             mem_waitrequest,
   input  logic                             mem_rd_valid
);

   localparam int BEAT_W     = $clog2(LINE_WORDS);
   localparam int WORD_BYTES = DATA_WIDTH / 8;
   localparam int LINE_BYTES = LINE_WORDS * WORD_BYTES;

   localparam logic [ADDR_WIDTH-1:0]     LINE_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);
   localparam logic [BEAT_W-1:0]         LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
   localparam logic [BURSTLEN_WIDTH-1:0] FULL_BURST = BURSTLEN_WIDTH'(LINE_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0]     WORD_STEP  = ADDR_WIDTH'(WORD_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      WR_BEAT,
      DONE
   } state_t;

   state_t                           state;
   logic [BEAT_W-1:0]                beat;
   logic [ADDR_WIDTH-1:0]            line_base;
   logic [LINE_WORDS*DATA_WIDTH-1:0] wr_line;

   logic [BEAT_W-1:0]                next_beat;
   logic [ADDR_WIDTH-1:0]            next_addr;

   // Address of the following write beat; the base is line aligned so the
   // offset never carries out of the line.
   always_comb begin
      next_beat = beat + BEAT_W'(1);
      next_addr = line_base + (ADDR_WIDTH'(next_beat) * WORD_STEP);
   end

   // Main controller: state, beat counter, line buffers and every output are
   // registered here so the memory side sees glitch-free commands.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         beat          <= '0;
         line_base     <= '0;
         wr_line       <= '0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         mem_addr      <= '0;
         mem_burst_len <= '0;
         mem_wdata     <= '0;
         mem_wr        <= 1'b0;
         mem_rd        <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  line_base <= req_addr & LINE_MASK;
                  wr_line   <= req_wdata;
                  beat      <= '0;
                  req_ready <= 1'b0;
                  mem_addr  <= req_addr & LINE_MASK;
                  if (req_wr) begin
                     state     <= WR_BEAT;
                     mem_wr    <= 1'b1;
                     mem_wdata <= req_wdata[DATA_WIDTH-1:0];
                  end else begin
                     state         <= RD_CMD;
                     mem_rd        <= 1'b1;
                     mem_burst_len <= FULL_BURST;
                  end
               end
            end
            RD_CMD: begin
               if (!mem_waitrequest) begin
                  state         <= RD_DATA;
                  mem_rd        <= 1'b0;
                  mem_addr      <= '0;
                  mem_burst_len <= '0;
               end
            end
            RD_DATA: begin
               if (mem_rd_valid) begin
                  rsp_rdata[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                  beat <= next_beat;
                  if (beat == LAST_BEAT) begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            WR_BEAT: begin
               if (!mem_waitrequest) begin
                  if (beat == LAST_BEAT) begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     mem_wr    <= 1'b0;
                     mem_addr  <= '0;
                     mem_wdata <= '0;
                  end else begin
                     beat      <= next_beat;
                     mem_addr  <= next_addr;
                     mem_wdata <= wr_line[int'(next_beat)*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               beat      <= '0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_master.sv
// tb_burst_master: directed, table-driven bench for burst_master with the
// default geometry (32-bit addresses and words, 4-word lines).
module tb_burst_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int BW = 2;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [AW-1:0]     req_addr;
   logic [LW*DW-1:0]  req_wdata;
   logic              rsp_valid;
   logic [LW*DW-1:0]  rsp_rdata;
   logic [AW-1:0]     mem_addr;
   logic [BW-1:0]     mem_burst_len;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;
   logic              mem_wr;
   logic              mem_rd;
   logic              mem_waitrequest;
   logic              mem_rd_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [127:0] line;
      int           cmd_waits;
      int           wait_beat;
      int           wait_len;
      int           gap;
      bit           stray;
      logic [31:0]  exp_base;
      int           exp_latency;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t tbl [6];
   vec_t recovery;

   burst_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .BURSTLEN_WIDTH(BW),
      .LINE_WORDS(LW)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wr(req_wr),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .mem_addr(mem_addr),
      .mem_burst_len(mem_burst_len),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_wr(mem_wr),
      .mem_rd(mem_rd),
      .mem_waitrequest(mem_waitrequest),
      .mem_rd_valid(mem_rd_valid)
   );

   // Free-running 100 MHz clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic wr,
                                input logic [31:0] addr, input logic [127:0] wdata);
      req_valid = valid;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   // Idle cycles with stray read beats; nothing may move and the last read
   // line must stay visible.
   task automatic idle_cycles(input int n, input logic [127:0] exp_rdata);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
         mem_waitrequest = 1'b0;
         mem_rd_valid    = 1'b1;
         mem_rdata       = 32'hDEAD_0000 + 32'(i);
         checkOutput("idle req_ready", req_ready, 1);
         checkOutput("idle mem cmd", {mem_rd, mem_wr}, 0);
         checkOutput("idle rsp_valid", rsp_valid, 0);
         checkOutput("idle rsp_rdata", rsp_rdata, exp_rdata);
      end
   endtask

   // One request acting as the memory: honours the vector's wait and gap
   // pattern and checks every command the block issues.
   task automatic run_vector(input vec_t v, input string tag);
      int k;
      int waits_left;
      int stall_left;
      int beats_sent;
      int gap_cnt;
      int wbeat;
      int rd_cycles;
      int wr_cycles;
      int overlaps;
      int ready_busy;
      bit cmd_accepted;
      bit done;
      waits_left   = v.cmd_waits;
      stall_left   = v.wait_len;
      beats_sent   = 0;
      gap_cnt      = 0;
      wbeat        = 0;
      rd_cycles    = 0;
      wr_cycles    = 0;
      overlaps     = 0;
      ready_busy   = 0;
      cmd_accepted = 1'b0;
      done         = 1'b0;
      @(negedge clock);
      checkOutput({tag, " ready"}, req_ready, 1);
      applyStimulus(1'b1, v.wr, v.addr, v.wr ? v.line : 128'h0);
      mem_waitrequest = 1'b0;
      mem_rd_valid    = 1'b0;
      mem_rdata       = '0;
      for (k = 1; k <= 40 && !done; k++) begin
         @(negedge clock);
         applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
         mem_waitrequest = 1'b0;
         mem_rd_valid    = 1'b0;
         mem_rdata       = '0;
         if (mem_rd && mem_wr) overlaps++;
         if (rsp_valid) begin
            checkOutput({tag, " latency"}, k, v.exp_latency);
            checkOutput({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
            done = 1'b1;
         end else begin
            if (req_ready) ready_busy++;
            if (v.stray) begin
               mem_rd_valid = 1'b1;
               mem_rdata    = 32'hBAD0_0000 + 32'(k);
            end
            if (cmd_accepted && beats_sent < LW) begin
               if (gap_cnt > 0) begin
                  gap_cnt--;
               end else begin
                  mem_rd_valid = 1'b1;
                  mem_rdata    = v.line[beats_sent*DW +: DW];
                  beats_sent++;
                  gap_cnt = v.gap;
               end
            end
            if (mem_rd) begin
               rd_cycles++;
               checkOutput({tag, " rd mem_addr"}, mem_addr, v.exp_base);
               checkOutput({tag, " rd burst_len"}, mem_burst_len, LW - 1);
               if (waits_left > 0) begin
                  mem_waitrequest = 1'b1;
                  waits_left--;
               end else begin
                  cmd_accepted = 1'b1;
               end
            end
            if (mem_wr && wbeat < LW) begin
               wr_cycles++;
               checkOutput({tag, " wr mem_addr"}, mem_addr, v.exp_base + 32'(wbeat * 4));
               checkOutput({tag, " wr mem_wdata"}, mem_wdata, v.line[wbeat*DW +: DW]);
               checkOutput({tag, " wr burst_len"}, mem_burst_len, 0);
               if (wbeat == v.wait_beat && stall_left > 0) begin
                  mem_waitrequest = 1'b1;
                  stall_left--;
               end else begin
                  wbeat++;
               end
            end
         end
      end
      if (!done) checkOutput({tag, " timeout"}, 0, 1);
      checkOutput({tag, " rd cmd cycles"}, rd_cycles, v.wr ? 0 : v.cmd_waits + 1);
      checkOutput({tag, " wr cmd cycles"}, wr_cycles, v.wr ? LW + v.wait_len : 0);
      checkOutput({tag, " rd/wr overlap"}, overlaps, 0);
      checkOutput({tag, " ready while busy"}, ready_busy, 0);
      @(negedge clock);
      mem_rd_valid = 1'b0;
      checkOutput({tag, " single pulse"}, rsp_valid, 0);
      checkOutput({tag, " back to idle"}, req_ready, 1);
   endtask

   // Reset values, the vector table, reset mid-burst, then continuous requests.
   initial begin : main
      int acc_count;
      int rsp_count;
      int overlaps;
      int rd_starts;
      bit prev_rd;
      int acc_cycle [8];
      int exp_acc [8];

      tbl[0] = '{1'b0, 32'h0000_1004, {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0},
                 0, 0, 0, 0, 1'b0, 32'h0000_1000, 6,
                 {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}};
      tbl[1] = '{1'b0, 32'h0000_3ABC, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                 3, 0, 0, 2, 1'b0, 32'h0000_3AB0, 15,
                 {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
      tbl[2] = '{1'b1, 32'h0000_2000, {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000},
                 0, 2, 2, 0, 1'b0, 32'h0000_2000, 7,
                 {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
      tbl[3] = '{1'b1, 32'h0000_201F, {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000},
                 0, 3, 1, 0, 1'b1, 32'h0000_2010, 6,
                 {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
      tbl[4] = '{1'b0, 32'hFFFF_FFF8, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000},
                 1, 0, 0, 1, 1'b0, 32'hFFFF_FFF0, 10,
                 {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}};
      tbl[5] = '{1'b1, 32'hFFFF_FFFC, {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
                 0, 0, 1, 0, 1'b1, 32'hFFFF_FFF0, 6,
                 {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}};
      recovery = '{1'b0, 32'h0000_4008, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000},
                   0, 0, 0, 0, 1'b0, 32'h0000_4000, 6,
                   {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000}};
      exp_acc = '{0, 6, 13, 19, 26, 32, 39, 45};

      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
      mem_waitrequest = 1'b0;
      mem_rd_valid    = 1'b0;
      mem_rdata       = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("reset req_ready", req_ready, 1);
      checkOutput("reset rsp_valid", rsp_valid, 0);
      checkOutput("reset mem cmd", {mem_rd, mem_wr}, 0);
      checkOutput("reset mem_addr", mem_addr, 0);
      checkOutput("reset burst_len", mem_burst_len, 0);
      checkOutput("reset mem_wdata", mem_wdata, 0);
      checkOutput("reset rsp_rdata", rsp_rdata, 0);
      reset_n = 1'b1;
      idle_cycles(2, 128'h0);

      for (int i = 0; i < 6; i++) begin
         run_vector(tbl[i], $sformatf("vec%0d", i));
         idle_cycles(2, tbl[i].exp_rdata);
      end

      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0000_4008, 128'h0);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
      checkOutput("rst-mid cmd", mem_rd, 1);
      @(negedge clock);
      mem_rd_valid = 1'b1;
      mem_rdata    = 32'h7700_0000;
      @(negedge clock);
      mem_rdata    = 32'h7700_0001;
      @(negedge clock);
      mem_rd_valid = 1'b0;
      checkOutput("rst-mid partial line", rsp_rdata,
                  {32'hCAFE_0003, 32'hCAFE_0002, 32'h7700_0001, 32'h7700_0000});
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst-mid req_ready", req_ready, 1);
      checkOutput("rst-mid rsp_valid", rsp_valid, 0);
      checkOutput("rst-mid mem cmd", {mem_rd, mem_wr}, 0);
      checkOutput("rst-mid mem_addr", mem_addr, 0);
      checkOutput("rst-mid burst_len", mem_burst_len, 0);
      checkOutput("rst-mid mem_wdata", mem_wdata, 0);
      checkOutput("rst-mid rsp_rdata", rsp_rdata, 0);
      @(negedge clock);
      reset_n = 1'b1;
      rsp_count = 0;
      for (int i = 0; i < 6; i++) begin
         mem_rd_valid = 1'b1;
         mem_rdata    = 32'h7700_0010 + 32'(i);
         @(negedge clock);
         if (rsp_valid) rsp_count++;
         checkOutput("rst-mid late beats ready", req_ready, 1);
      end
      mem_rd_valid = 1'b0;
      checkOutput("rst-mid no rsp", rsp_count, 0);
      checkOutput("rst-mid line after", rsp_rdata, 0);
      run_vector(recovery, "recovery");
      idle_cycles(1, recovery.exp_rdata);

      acc_count = 0;
      rsp_count = 0;
      overlaps  = 0;
      rd_starts = 0;
      prev_rd   = 1'b0;
      for (int c = 0; c < 52; c++) begin
         @(negedge clock);
         if (rsp_valid) rsp_count++;
         if (mem_rd && mem_wr) overlaps++;
         if (mem_rd && !prev_rd) rd_starts++;
         prev_rd         = mem_rd;
         req_valid       = 1'b1;
         req_addr        = 32'h0000_5000;
         req_wdata       = {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
         mem_waitrequest = 1'b0;
         mem_rd_valid    = 1'b1;
         mem_rdata       = 32'hC000_0000 + 32'(c);
         if (req_ready) begin
            if (acc_count < 8) acc_cycle[acc_count] = c;
            req_wr = (acc_count % 2 == 0);
            acc_count++;
         end
      end
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
      mem_rd_valid = 1'b0;
      checkOutput("b2b final idle", req_ready, 1);
      checkOutput("b2b acceptances", acc_count, 8);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("b2b accept %0d cycle", i), acc_cycle[i], exp_acc[i]);
      end
      checkOutput("b2b rsp pulses", rsp_count, 8);
      checkOutput("b2b rd/wr overlap", overlaps, 0);
      checkOutput("b2b read commands", rd_starts, 4);
      checkOutput("b2b last line", rsp_rdata,
                  {32'hC000_0032, 32'hC000_0031, 32'hC000_0030, 32'hC000_002F});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_master.md
BURST_MASTER -- requirements
Module: burst_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width on both sides.
REQ-002 Parameter DATA_WIDTH, default 32, memory word width in bits; must be a multiple of 8.
REQ-003 Parameter BURSTLEN_WIDTH, default 2, width of mem_burst_len.
REQ-004 Parameter LINE_WORDS, default 4, words per line; power of two, 2..2**BURSTLEN_WIDTH.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  client line request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_wr  input  1  1 = line write, 0 = line read.
REQ-010 req_addr  input  ADDR_WIDTH  line byte address; low log2(LINE_WORDS*DATA_WIDTH/8) bits ignored.
REQ-011 req_wdata  input  LINE_WORDS*DATA_WIDTH  write line; word 0 in the least-significant bits.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  LINE_WORDS*DATA_WIDTH  read line, same packing as req_wdata.
REQ-014 mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-015 mem_burst_len  output  BURSTLEN_WIDTH  beats minus one.
REQ-016 mem_wdata  output  DATA_WIDTH  write word to memory.
REQ-017 mem_rdata  input  DATA_WIDTH  read word from memory.
REQ-018 mem_wr / mem_rd  output  1 each  write / read command.
REQ-019 mem_waitrequest  input  1  memory stalls the current command.
REQ-020 mem_rd_valid  input  1  mem_rdata valid this cycle.

Function
REQ-021 States IDLE, RD_CMD, RD_DATA, WR_BEAT, DONE; registered state; beat counter of width log2(LINE_WORDS).
REQ-022 IDLE: req_ready=1, all other outputs inactive; on req_valid latch line base (aligned req_addr), req_wr, req_wdata, clear beat counter; go to WR_BEAT if req_wr else RD_CMD.
REQ-023 req_ready SHALL be 0 in every state except IDLE; requests outside IDLE are not sampled.
REQ-024 RD_CMD: mem_rd=1, mem_addr=line base, mem_burst_len=LINE_WORDS-1, all held stable while mem_waitrequest=1; first cycle with mem_waitrequest=0 -> RD_DATA.
REQ-025 RD_DATA: mem_rd=0; each cycle with mem_rd_valid=1 store mem_rdata into word[beat], increment beat; beat LINE_WORDS-1 captured -> DONE.
REQ-026 mem_rd_valid outside RD_DATA SHALL be ignored; gaps between valid beats are legal and SHALL NOT time out.
REQ-027 WR_BEAT: mem_wr=1, mem_burst_len=0, mem_addr=line base + beat*(DATA_WIDTH/8), mem_wdata=word[beat]; hold while mem_waitrequest=1; on mem_waitrequest=0 advance beat; last beat accepted -> DONE.
REQ-028 mem_rd and mem_wr SHALL never be asserted in the same cycle.
REQ-029 Address arithmetic modulo 2**ADDR_WIDTH; beats never cross the line (no wrap within line needed since base is aligned).
REQ-030 DONE: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata holds the captured line until the next read's first captured beat; on writes rsp_rdata is unchanged.
REQ-031 Minimum latency, zero wait states: read = accept + 1 cmd cycle + LINE_WORDS data cycles (memory-dependent) + DONE; write = accept + LINE_WORDS beats + DONE (rsp_valid LINE_WORDS+1 cycles after acceptance).
REQ-032 Back-to-back: a new request is accepted no earlier than the cycle after DONE.

Reset
REQ-033 reset_n low SHALL immediately force state IDLE, beat counter 0, req_ready=1 after release, rsp_valid=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_burst_len=0, mem_wdata=0, rsp_rdata=0.
REQ-034 Reset mid-burst SHALL abandon the transaction with no rsp_valid; beats arriving after release are ignored per REQ-026.

Verification
REQ-035 Read, no waits: req_addr=0x1004, memory returns 0xA0..0xA3 -> mem_addr=0x1000, mem_burst_len=3 for one cycle, rsp_rdata words 0..3 = 0xA0..0xA3, single rsp_valid pulse.
REQ-036 Read, 3 waitrequest cycles then valid beats with 2-cycle gaps -> mem_rd/mem_addr stable 4 cycles, line captured correctly, no early rsp_valid.
REQ-037 Write, waitrequest on beat 2 for 2 cycles: req_addr=0x2000 -> mem_addr 0x2000,0x2004,0x2008(x3),0x200C with matching words; rsp_valid 7 cycles after acceptance.
REQ-038 Stray mem_rd_valid in IDLE and WR_BEAT -> no state or rsp_rdata change.
REQ-039 reset_n pulsed low after beat 1 of a read -> all outputs at reset values, no rsp_valid; next read completes normally.
REQ-040 req_valid held high continuously, alternating wr/rd -> exactly one acceptance per IDLE visit, never mem_rd and mem_wr together.
